mem_arbiter: RTL and testbench

- Parametrised successor to the single fetch/data address mux in the CPU top. It arbitrates NUM_PORTS requesters (e.g. port 0 instruction fetch, port 1 load/store, further ports for DMA or display) onto one synchronous memory.
- Each port uses a valid/ready request handshake and receives a read-response strobe. The memory is fully pipelined with a fixed read latency, so one request is accepted per cycle.
- Supports fixed-priority or round-robin arbitration.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// N-port valid/ready arbiter onto one pipelined synchronous memory.
// Fixed-priority or round-robin grant, in-order read response tracking.
module mem_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  generate
    if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
      $error("mem_arbiter: NUM_PORTS must be 1..8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
      $error("mem_arbiter: READ_LATENCY must be 1..4");
    end
  endgenerate

  logic [PW-1:0]           ptr;
  logic [PW-1:0]           win;
  logic                    found;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [READ_LATENCY-1:0] tv;
  logic [PW-1:0]           tid [READ_LATENCY];
  int                      start;
  int                      idx;

  // Search order begins at ptr+1 in round-robin, at port 0 otherwise.
  always_comb begin
    found = 1'b0;
    win   = '0;
    start = 0;
    idx   = 0;
    if (ARB_MODE == 1) start = int'(ptr) + 1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = start + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!rst && !found && p == idx && req_valid[p]) begin
          found = 1'b1;
          win   = PW'(p);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (found && win == PW'(p)) begin
        req_ready[p] = 1'b1;
        mem_we       = req_we[p];
        mem_addr     = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata    = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= PW'(NUM_PORTS - 1);
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (found) begin
      ptr     <= win;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Read tracker: {valid, port} travels alongside the memory pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tid[i] <= '0;
    end else begin
      tv[0]  <= found & ~mem_we;
      tid[0] <= win;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tv[i]  <= tv[i-1];
        tid[i] <= tid[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_valid[p] = tv[READ_LATENCY-1] && (tid[READ_LATENCY-1] == PW'(p));
    end
  end

  assign rsp_rdata = mem_rdata;
  assign busy      = |tv;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: fixed-priority, round-robin
// and latency-3 instances, each with a write-first memory model.
module tb_mem_arbiter;

  typedef struct {
    logic [7:0]  mask;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t fp_q[$];
  exp_t rr_q[$];
  exp_t l3_q[$];

  // fixed priority, 2 ports, latency 1
  logic [1:0]  fp_valid, fp_ready, fp_we, fp_rsp_valid;
  logic [63:0] fp_addr, fp_wdata;
  logic [31:0] fp_rsp_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
  logic        fp_mem_we, fp_busy;

  mem_arbiter #(.NUM_PORTS(2), .READ_LATENCY(1), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst(rst),
    .req_valid(fp_valid), .req_ready(fp_ready), .req_we(fp_we),
    .req_addr(fp_addr), .req_wdata(fp_wdata),
    .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata),
    .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata),
    .busy(fp_busy)
  );

  // round-robin, 3 ports, latency 1
  logic [2:0]  rr_valid, rr_ready, rr_we, rr_rsp_valid;
  logic [95:0] rr_addr, rr_wdata;
  logic [31:0] rr_rsp_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
  logic        rr_mem_we, rr_busy;

  mem_arbiter #(.NUM_PORTS(3), .READ_LATENCY(1), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .req_valid(rr_valid), .req_ready(rr_ready), .req_we(rr_we),
    .req_addr(rr_addr), .req_wdata(rr_wdata),
    .rsp_valid(rr_rsp_valid), .rsp_rdata(rr_rsp_rdata),
    .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
    .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata),
    .busy(rr_busy)
  );

  // fixed priority, 2 ports, latency 3
  logic [1:0]  l3_valid, l3_ready, l3_we, l3_rsp_valid;
  logic [63:0] l3_addr, l3_wdata;
  logic [31:0] l3_rsp_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;
  logic        l3_mem_we, l3_busy;

  mem_arbiter #(.NUM_PORTS(2), .READ_LATENCY(3), .ARB_MODE(0)) u_l3 (
    .clk(clk), .rst(rst),
    .req_valid(l3_valid), .req_ready(l3_ready), .req_we(l3_we),
    .req_addr(l3_addr), .req_wdata(l3_wdata),
    .rsp_valid(l3_rsp_valid), .rsp_rdata(l3_rsp_rdata),
    .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata),
    .busy(l3_busy)
  );

  // Write-first synchronous memory models
  logic [31:0] fp_mem [256];
  logic [31:0] rr_mem [256];
  logic [31:0] l3_mem [256];
  logic [31:0] fp_rd, rr_rd;
  logic [31:0] l3_rd [3];

  always @(posedge clk) begin
    if (fp_mem_we) fp_mem[fp_mem_addr[9:2]] <= fp_mem_wdata;
    fp_rd <= fp_mem_we ? fp_mem_wdata : fp_mem[fp_mem_addr[9:2]];
    if (rr_mem_we) rr_mem[rr_mem_addr[9:2]] <= rr_mem_wdata;
    rr_rd <= rr_mem_we ? rr_mem_wdata : rr_mem[rr_mem_addr[9:2]];
    if (l3_mem_we) l3_mem[l3_mem_addr[9:2]] <= l3_mem_wdata;
    l3_rd[0] <= l3_mem_we ? l3_mem_wdata : l3_mem[l3_mem_addr[9:2]];
    l3_rd[1] <= l3_rd[0];
    l3_rd[2] <= l3_rd[1];
  end

  assign fp_mem_rdata = fp_rd;
  assign rr_mem_rdata = rr_rd;
  assign l3_mem_rdata = l3_rd[2];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    total++;
    $display("FAIL %s: got rsp_valid %0h expected no response", name, act);
  endtask

  // Monitors: pop and compare whenever a response strobe appears
  exp_t fp_e, rr_e, l3_e;

  always @(negedge clk) begin
    if (fp_rsp_valid != 0) begin
      if (fp_q.size() == 0) unexpected("fp_rsp", 64'(fp_rsp_valid));
      else begin
        fp_e = fp_q.pop_front();
        chk("fp_rsp_port", 64'(fp_rsp_valid), 64'(fp_e.mask));
        chk("fp_rsp_data", 64'(fp_rsp_rdata), 64'(fp_e.data));
        chk("fp_rsp_cycle", 64'(cyc), 64'(fp_e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (rr_rsp_valid != 0) begin
      if (rr_q.size() == 0) unexpected("rr_rsp", 64'(rr_rsp_valid));
      else begin
        rr_e = rr_q.pop_front();
        chk("rr_rsp_port", 64'(rr_rsp_valid), 64'(rr_e.mask));
        chk("rr_rsp_data", 64'(rr_rsp_rdata), 64'(rr_e.data));
        chk("rr_rsp_cycle", 64'(cyc), 64'(rr_e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (l3_rsp_valid != 0) begin
      if (l3_q.size() == 0) unexpected("l3_rsp", 64'(l3_rsp_valid));
      else begin
        l3_e = l3_q.pop_front();
        chk("l3_rsp_port", 64'(l3_rsp_valid), 64'(l3_e.mask));
        chk("l3_rsp_data", 64'(l3_rsp_rdata), 64'(l3_e.data));
        chk("l3_rsp_cycle", 64'(cyc), 64'(l3_e.due));
      end
    end
  end

  initial begin
    fp_mem[64] <= 32'h0000_1100;
    fp_mem[128] <= 32'h0000_2200;
    rr_mem[4] <= 32'h0000_00A0;
    rr_mem[8] <= 32'h0000_00A1;
    rr_mem[12] <= 32'h0000_00A2;
    l3_mem[0] <= 32'h0000_000A;
    l3_mem[1] <= 32'h0000_000B;
    l3_mem[2] <= 32'h0000_000C;

    fp_valid = 2'b11; fp_we = 2'b11;
    fp_addr = {32'h0000_0200, 32'h0000_0100};
    fp_wdata = {32'h1111_1111, 32'h2222_2222};
    rr_valid = '0; rr_we = '0;
    rr_addr = {32'h30, 32'h20, 32'h10}; rr_wdata = '0;
    l3_valid = '0; l3_we = '0; l3_addr = '0; l3_wdata = '0;

    // reset state with requests pending
    #2;
    chk("rst_ready", 64'(fp_ready), 64'h0);
    chk("rst_mem_we", 64'(fp_mem_we), 64'h0);
    chk("rst_mem_addr", 64'(fp_mem_addr), 64'h0);
    chk("rst_mem_wdata", 64'(fp_mem_wdata), 64'h0);
    chk("rst_busy", 64'(fp_busy), 64'h0);
    chk("rst_rsp", 64'(fp_rsp_valid), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fp_valid = '0; fp_we = '0;

    // fixed priority: both read, port0 wins then port1
    @(negedge clk);
    fp_valid = 2'b11;
    #1;
    chk("fp_grant0", 64'(fp_ready), 64'h1);
    chk("fp_read_we", 64'(fp_mem_we), 64'h0);
    chk("fp_addr0", 64'(fp_mem_addr), 64'h100);
    fp_q.push_back('{8'h01, 32'h0000_1100, cyc + 1});
    @(negedge clk);
    fp_valid = 2'b10;
    #1;
    chk("fp_grant1", 64'(fp_ready), 64'h2);
    chk("fp_addr1", 64'(fp_mem_addr), 64'h200);
    fp_q.push_back('{8'h02, 32'h0000_2200, cyc + 1});
    @(negedge clk);
    fp_valid = 2'b00;
    #1;
    chk("fp_idle_ready", 64'(fp_ready), 64'h0);
    chk("fp_idle_addr_hold", 64'(fp_mem_addr), 64'h200);

    // write then read back the same address
    @(negedge clk);
    fp_valid = 2'b01; fp_we = 2'b01;
    fp_addr[31:0] = 32'h40; fp_wdata[31:0] = 32'hDEAD_BEEF;
    #1;
    chk("wr_ready", 64'(fp_ready), 64'h1);
    chk("wr_mem_we", 64'(fp_mem_we), 64'h1);
    chk("wr_mem_addr", 64'(fp_mem_addr), 64'h40);
    chk("wr_mem_wdata", 64'(fp_mem_wdata), 64'hDEAD_BEEF);
    @(negedge clk);
    fp_we = 2'b00;
    #1;
    chk("rd_ready", 64'(fp_ready), 64'h1);
    chk("rd_mem_we", 64'(fp_mem_we), 64'h0);
    fp_q.push_back('{8'h01, 32'hDEAD_BEEF, cyc + 1});
    @(negedge clk);
    fp_valid = 2'b00;
    #1;
    chk("post_rd_mem_we", 64'(fp_mem_we), 64'h0);
    repeat (2) @(negedge clk);

    // reset mid-operation discards an in-flight read
    fp_valid = 2'b01; fp_addr[31:0] = 32'h100;
    #1;
    chk("mid_ready", 64'(fp_ready), 64'h1);
    @(posedge clk);
    #2;
    chk("mid_busy", 64'(fp_busy), 64'h1);
    fp_valid = 2'b10; fp_we = 2'b10; fp_addr[63:32] = 32'h80;
    #1;
    chk("mid_wr_we", 64'(fp_mem_we), 64'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(fp_ready), 64'h0);
    chk("mid_rst_we", 64'(fp_mem_we), 64'h0);
    chk("mid_rst_busy", 64'(fp_busy), 64'h0);
    chk("mid_rst_rsp", 64'(fp_rsp_valid), 64'h0);
    chk("mid_rst_addr", 64'(fp_mem_addr), 64'h0);
    chk("mid_rst_wdata", 64'(fp_mem_wdata), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    fp_valid = '0; fp_we = '0;
    repeat (3) @(negedge clk);

    // round-robin: 0,1,2,0,1,2 with all ports valid
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      rr_valid = 3'b111;
      #1;
      chk($sformatf("rr_grant%0d", i), 64'(rr_ready), 64'(1 << (i % 3)));
      rr_q.push_back('{8'(1 << (i % 3)), 32'hA0 + 32'(i % 3), cyc + 1});
    end
    @(negedge clk);
    rr_valid = 3'b010;
    #1;
    chk("rr_hold_grant1", 64'(rr_ready), 64'h2);
    rr_q.push_back('{8'h02, 32'hA1, cyc + 1});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rr_valid = 3'b000;
      #1;
      chk("rr_idle_ready", 64'(rr_ready), 64'h0);
    end
    @(negedge clk);
    rr_valid = 3'b011;
    #1;
    chk("rr_after_idle", 64'(rr_ready), 64'h1);
    rr_q.push_back('{8'h01, 32'hA0, cyc + 1});
    @(negedge clk);
    rr_valid = 3'b000;

    // latency 3 back-to-back reads on port1
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      l3_valid = 2'b10;
      l3_addr[63:32] = 32'(4 * i);
      #1;
      chk($sformatf("l3_busy_issue%0d", i), 64'(l3_busy), 64'(i > 0));
      chk($sformatf("l3_grant%0d", i), 64'(l3_ready), 64'h2);
      l3_q.push_back('{8'h02, 32'hA + 32'(i), cyc + 3});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      l3_valid = 2'b00;
      #1;
      chk($sformatf("l3_busy_drain%0d", k), 64'(l3_busy), 64'(k < 3));
    end

    repeat (6) @(negedge clk);
    chk("fp_q_empty", 64'(fp_q.size()), 64'h0);
    chk("rr_q_empty", 64'(rr_q.size()), 64'h0);
    chk("l3_q_empty", 64'(l3_q.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
